// File: rtl/mlu_ctrl.sv
// Sequencer for the combinational 32x32 multiplier: holds operands stable for
// LATENCY cycles, captures the product into HI/LO and stalls EX while busy.
module mlu_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_sign,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        req_ready,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic        mul_start_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          capture;

  assign accept  = (state == IDLE) && req_valid && !flush;
  assign capture = (state == BUSY) && !flush && (cnt == CW'(LATENCY - 1));
  assign stall_o = req_valid && !flush && (state != DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= '0;
      else if (state == BUSY)
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_sign_o <= 1'b0;
      mul_op1_o  <= '0;
      mul_op2_o  <= '0;
    end else if (accept) begin
      mul_sign_o <= req_sign;
      mul_op1_o  <= req_op1;
      mul_op2_o  <= req_op2;
    end
  end

  // MT writes only land in IDLE, so a product capture can never race them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (capture) begin
      hi_o <= mul_result_i[63:32];
      lo_o <= mul_result_i[31:0];
    end else if (state == IDLE) begin
      if (mthi_we)
        hi_o <= mt_data;
      if (mtlo_we)
        lo_o <= mt_data;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    mul_start_o = 1'b0;
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_nxt = BUSY;
      end
      BUSY: begin
        mul_start_o = 1'b1;
        if (flush)
          state_nxt = IDLE;
        else if (capture)
          state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
